// File: rtl/alu_mc_pkg.sv
// Shared opcode and FSM state encodings for the multi-cycle ALU.
package alu_mc_pkg;

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_SUB   = 4'd3;
   localparam logic [3:0] OP_SLT   = 4'd4;
   localparam logic [3:0] OP_SLTU  = 4'd5;
   localparam logic [3:0] OP_XOR   = 4'd6;
   localparam logic [3:0] OP_NOR   = 4'd7;
   localparam logic [3:0] OP_SLL   = 4'd8;
   localparam logic [3:0] OP_SRL   = 4'd9;
   localparam logic [3:0] OP_SRA   = 4'd10;
   localparam logic [3:0] OP_MUL   = 4'd11;
   localparam logic [3:0] OP_MULHU = 4'd12;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   function automatic logic is_mul(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULHU);
   endfunction

endpackage

// File: rtl/alu_mc_comb.sv
// Combinational datapath for every single-cycle op and its flags.
import alu_mc_pkg::*;

module alu_mc_comb #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o,
   output logic             carry_o,
   output logic             ovf_o
);

   logic             sub;
   logic [WIDTH-1:0] bb;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic [SHW-1:0]   sh;

   always_comb begin
      sub = (op_i == OP_SUB) || (op_i == OP_SLT) || (op_i == OP_SLTU);
      bb  = sub ? ~b_i : b_i;
      {cout, sum} = {1'b0, a_i} + {1'b0, bb} + (WIDTH+1)'(sub);
      // overflow is judged against the effective (possibly inverted) B
      ovf = (a_i[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      sh  = b_i[SHW-1:0];
      y_o     = '0;
      carry_o = 1'b0;
      ovf_o   = 1'b0;
      case (op_i)
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_NOR:  y_o = ~(a_i | b_i);
         OP_ADD, OP_SUB: begin
            y_o     = sum;
            carry_o = cout;
            ovf_o   = ovf;
         end
         OP_SLT: begin
            y_o     = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            carry_o = cout;
         end
         OP_SLTU: begin
            y_o     = {{(WIDTH-1){1'b0}}, ~cout};
            carry_o = cout;
         end
         OP_SLL:  y_o = a_i << sh;
         OP_SRL:  y_o = a_i >> sh;
         OP_SRA:  y_o = $signed(a_i) >>> sh;
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: handshake FSM, shift-add multiplier, registered outputs.
import alu_mc_pkg::*;

module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow
);

   logic [1:0]         state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               hi_q, hi_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;

   logic [WIDTH-1:0]   cy;
   logic               ccarry;
   logic               covf;
   logic [2*WIDTH-1:0] prod_add;
   logic [WIDTH-1:0]   ymul;

   alu_mc_comb #(.WIDTH(WIDTH), .SHW(SHW)) u_comb (
      .op_i    (op),
      .a_i     (a),
      .b_i     (b),
      .y_o     (cy),
      .carry_o (ccarry),
      .ovf_o   (covf)
   );

   assign in_ready  = (state_q == S_IDLE) && !reset;
   assign out_valid = (state_q == S_DONE);
   assign y         = y_q;
   assign zero      = zero_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;

   always_comb begin
      prod_add = prod_q + (mplier_q[0] ? mcand_q : '0);
      ymul     = hi_q ? prod_add[2*WIDTH-1:WIDTH] : prod_add[WIDTH-1:0];
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      hi_d     = hi_q;
      y_d      = y_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (is_mul(op)) begin
                  mcand_d  = {{WIDTH{1'b0}}, a};
                  mplier_d = b;
                  prod_d   = '0;
                  cnt_d    = '0;
                  hi_d     = (op == OP_MULHU);
                  state_d  = S_MUL;
               end else begin
                  y_d     = cy;
                  zero_d  = (cy == '0);
                  carry_d = ccarry;
                  ovf_d   = covf;
                  state_d = S_DONE;
               end
            end
         end
         S_MUL: begin
            prod_d   = prod_add;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            // last iteration: publish the sum that includes this cycle's add
            if (cnt_q == SHW'(WIDTH-1)) begin
               y_d     = ymul;
               zero_d  = (ymul == '0);
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         hi_q     <= 1'b0;
         y_q      <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         hi_q     <= hi_d;
         y_q      <= y_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32.
import alu_mc_pkg::*;

module tb_alu_mc;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        zero;
   logic        carry_out;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   alu_mc #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .zero      (zero),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] flags();
      return {zero, carry_out, overflow};
   endfunction

   task automatic run_op(input logic [3:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, output int lat,
                         output bit rdy_low);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_wait", in_ready, 1);
      op = o;
      a = aa;
      b = bb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = ~aa;
      b = ~bb;
      op = OP_AND;
      lat = 1;
      rdy_low = 1'b1;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_low = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic retire(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_retire_vld"}, out_valid, 0);
      check({tag, "_retire_rdy"}, in_ready, 1);
   endtask

   task automatic do_op(input string tag, input logic [3:0] o,
                        input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] ey, input logic [2:0] ef,
                        input int elat);
      int  lat;
      bit  rl;
      run_op(o, aa, bb, lat, rl);
      check({tag, "_lat"}, lat, elat);
      check({tag, "_y"}, y, ey);
      check({tag, "_flags"}, flags(), ef);
      if (elat > 1) check({tag, "_rdy_low"}, rl, 1);
      retire(tag);
   endtask

   initial begin
      int  lat;
      bit  rl;
      bit  bad;
      logic [31:0] yh;
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      op = '0;
      a = '0;
      b = '0;
      #3;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_y", y, 0);
      check("rst_flags", flags(), 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rel_in_ready", in_ready, 1);

      // flags are {zero, carry_out, overflow}
      do_op("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 3'b001, 1);
      do_op("sub_eq",  OP_SUB, 32'd5, 32'd5, 32'h0, 3'b110, 1);
      do_op("sltu",    OP_SLTU, 32'd1, 32'd2, 32'h1, 3'b000, 1);
      do_op("slt_neg", OP_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 3'b010, 1);
      do_op("xor",     OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 3'b000, 1);
      do_op("nor",     OP_NOR, 32'h0, 32'h0, 32'hFFFFFFFF, 3'b000, 1);
      do_op("and",     OP_AND, 32'h0F, 32'hF0, 32'h0, 3'b100, 1);
      do_op("or",      OP_OR, 32'h0F, 32'hF0, 32'hFF, 3'b000, 1);
      do_op("sra",     OP_SRA, 32'h80000000, 32'h24, 32'hF8000000, 3'b000, 1);
      do_op("srl",     OP_SRL, 32'h80000000, 32'h24, 32'h08000000, 3'b000, 1);
      do_op("sll",     OP_SLL, 32'h1, 32'd31, 32'h80000000, 3'b000, 1);
      do_op("undef",   4'd13, 32'h1234, 32'h5678, 32'h0, 3'b100, 1);
      do_op("mul",     OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 3'b000, 33);
      do_op("mulhu",   OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3'b000, 33);
      do_op("mul_zero", OP_MUL, 32'h10000, 32'h10000, 32'h0, 3'b100, 33);
      do_op("mulhu_sm", OP_MULHU, 32'h10000, 32'h10000, 32'h1, 3'b000, 33);

      run_op(OP_ADD, 32'd2, 32'd3, lat, rl);
      check("bp_y", y, 5);
      yh = y;
      bad = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      op = OP_SUB;
      a = 32'd9;
      b = 32'd1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (y !== yh || !out_valid || in_ready) bad = 1'b1;
      end
      check("bp_hold", bad, 0);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_idle_vld", out_valid, 0);
      check("bp_idle_rdy", in_ready, 1);
      check("bp_ignored", y, 5);

      @(negedge clk);
      op = OP_MUL;
      a = 32'd3;
      b = 32'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("mrst_vld", out_valid, 0);
      check("mrst_y", y, 0);
      check("mrst_rdy", in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mrst_rel_rdy", in_ready, 1);
      do_op("post_rst_add", OP_ADD, 32'd2, 32'd3, 32'd5, 3'b000, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU; next generation of the 32-bit ripple ALU in the single-cycle datapath.
- Width is configurable. Adds shifts, XOR/NOR, unsigned compare and an iterative shift-add multiplier.
- Operand input and result output use valid/ready handshakes, so the block can sit between decode and writeback in a multi-cycle core.
- Results and flags are registered.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk input 1 — single clock, rising edge.
- reset input 1 — asynchronous, active-high.
- in_valid input 1 — operands and op are presented.
- in_ready output 1 — block accepts a new op.
- op input 4 — operation code (see package).
- a input WIDTH — operand A.
- b input WIDTH — operand B; for shifts, b[SHW-1:0] is the shift amount.
- out_valid output 1 — result and flags valid.
- out_ready input 1 — consumer takes the result.
- y output WIDTH — result.
- zero output 1 — y == 0.
- carry_out output 1 — adder carry (ADD/SUB/SLT/SLTU only, else 0).
- overflow output 1 — signed overflow (ADD/SUB only, else 0).

Behaviour:
- Reset values: in_ready=0 during reset, 1 after release; out_valid=0; y=0; zero=0; carry_out=0; overflow=0; state=IDLE; iteration counter=0.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready at a rising edge. Op and operands are captured only at acceptance; later input changes are ignored.
  - Single-cycle op: compute and register y and flags, go to DONE. out_valid is high on the next cycle (latency 1).
  - MUL/MULHU: load the multiplicand into a 2·WIDTH register, load the multiplier, clear the product accumulator and the counter, go to MUL.
- MUL:
  - in_ready=0.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the product; shift the multiplicand left and the multiplier right; increment the counter.
  - Add, shift and counter update all use pre-shift register values within the same edge.
  - Ten counter reaches WIDTH-1, go to DONE; the final cycle's addition is included in the registered result.
  - y = product[WIDTH-1:0] (MUL) or product[2·WIDTH-1:WIDTH] (MULHU).
  - Latency from acceptance to out_valid is WIDTH+1 cycles (33 at WIDTH=32).
  - Flags: zero reflects y; carry_out=0; overflow=0.
- DONE:
  - out_valid=1; in_ready=0.
  - y and flags are held stable until out_ready. out_ready while in IDLE or MUL has no effect.
  - On out_valid&&out_ready, go to IDLE and drop out_valid. Next acceptance is possible one cycle later, so simple-op throughput is 1 op per 2 cycles.
- Arithmetic:
  - SUB/SLT/SLTU compute a + ~b + 1.
  - carry_out = carry from bit WIDTH-1.
  - overflow = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), where b' is the effective (inverted for SUB) B.
  - SLT: y = {0…, sum[MSB]^overflow}. SLTU: y = {0…, ~carry_out}.
  - SRA replicates a[MSB]. Shift amounts ≥WIDTH are impossible because only SHW bits are used.
- Undefined op codes (13–15): accepted normally, latency 1, y=0, zero=1, other flags 0.
- Reset mid-operation, including inside MUL: aborts immediately to the reset state; any partial product is discarded.
- in_valid while in_ready=0: ignored. The producer holds its signals until accepted.

Decomposition:
- Package alu_mc_pkg holds:
  - op localparams: AND=0, OR=1, ADD=2, SUB=3, SLT=4, SLTU=5, XOR=6, NOR=7, SLL=8, SRL=9, SRA=10, MUL=11, MULHU=12.
  - state encoding: IDLE=0, MUL=1, DONE=2.
- One sub-module: alu_mc_comb. It is purely combinational and covers all single-cycle ops and flags, parametrised by WIDTH.
- The top holds the FSM, the multiplier registers and the output registers.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+0x00000001, out_ready=1 → out_valid 1 cycle after accept; y=0x80000000, overflow=1, carry_out=0, zero=0.
- SUB 5−5 then SLTU 1,2 → first result y=0, zero=1, carry_out=1; second result y=1, carry_out=0.
- MUL 0xFFFFFFFF×0xFFFFFFFF → MUL y=0x00000001; MULHU y=0xFFFFFFFE; out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- SRA 0x80000000 by b=0x24 (amount 4) → y=0xF8000000; SLL 1 by 31 → y=0x80000000.
- Backpressure: out_ready=0 for 10 cycles after a result → y held stable, out_valid held, in_ready=0, new in_valid ignored; raise out_ready → IDLE next cycle.
- Assert reset at MUL iteration 10 → out_valid=0 and y=0 immediately (async); after release, in_ready=1 and a new ADD 2+3 gives y=5.
